// File: rtl/harris_pkg.sv
// Shared definitions for the Harris 3x3 window stream: default sample width,
// window geometry, flat window index helper and packed window type.
package harris_pkg;
  localparam int HARRIS_DATA_W = 32;
  localparam int WIN = 3;

  typedef logic [WIN*WIN*HARRIS_DATA_W-1:0] win_t;

  // Slot of win[r][c] inside a flat window vector, in units of one sample.
  function automatic int win_idx(input int r, input int c);
    return r * WIN + c;
  endfunction
endpackage

// File: rtl/harris_window_gen_if.sv
// Sample-in / window-out handshake bundle of the Harris window generator.
// The master side is the generator; the slave side feeds samples and takes windows.
interface harris_window_gen_if
  import harris_pkg::*;
#(
  parameter int DATA_W = HARRIS_DATA_W,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_sof;
  logic signed [DATA_W-1:0]  in_data;
  logic                      win_valid;
  logic                      win_ready;
  logic [WIN*WIN*DATA_W-1:0] win_data;
  logic [XW-1:0]             win_x;
  logic [YW-1:0]             win_y;

  modport master (
    input  in_valid, in_sof, in_data, win_ready,
    output in_ready, win_valid, win_data, win_x, win_y
  );

  modport slave (
    output in_valid, in_sof, in_data, win_ready,
    input  in_ready, win_valid, win_data, win_x, win_y
  );
endinterface

// File: rtl/harris_line_buffer.sv
// One line of response samples: single address shared by read and write,
// asynchronous read returns the value stored before this cycle's write.
module harris_line_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 640,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            addr,
  input  logic signed [DATA_W-1:0] wdata,
  output logic signed [DATA_W-1:0] rdata
);
  logic signed [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/harris_window_gen.sv
// Raster stream of signed Harris responses in, every interior 3x3 neighbourhood
// out with its centre coordinates; two line buffers hold the previous rows.
module harris_window_gen
  import harris_pkg::*;
#(
  parameter int DATA_W = HARRIS_DATA_W,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                clk,
  input  logic                reset,
  harris_window_gen_if.master bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0] col_q, col_eff, col_nxt;
  logic [YW-1:0] row_q, row_eff, row_nxt;
  logic          in_ready, accept, emit;

  logic signed [DATA_W-1:0]  lb0_rd, lb1_rd;
  logic [WIN*DATA_W-1:0]     new_col;
  logic [WIN*WIN*DATA_W-1:0] win_nxt;

  logic                      win_vld_p1;
  logic [WIN*WIN*DATA_W-1:0] win_data_p1;
  logic [XW-1:0]             win_x_p1;
  logic [YW-1:0]             win_y_p1;

  assign in_ready = !win_vld_p1 || bus.win_ready;
  assign accept   = bus.in_valid && in_ready;

  // Position of the sample now on the input; start-of-frame overrides the counters.
  always_comb begin
    col_eff = bus.in_sof ? '0 : col_q;
    row_eff = bus.in_sof ? '0 : row_q;
    col_nxt = col_eff + XW'(1);
    row_nxt = row_eff;
    if (col_eff == XW'(IMG_W - 1)) begin
      col_nxt = '0;
      row_nxt = (row_eff == YW'(IMG_H - 1)) ? '0 : row_eff + YW'(1);
    end
    emit = accept && (col_eff >= XW'(2)) && (row_eff >= YW'(2));
  end

  harris_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_eff),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  harris_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_eff),
    .wdata (bus.in_data),
    .rdata (lb1_rd)
  );

  // Row r of the incoming column: r=0 two lines up, r=2 the live sample.
  assign new_col = {bus.in_data, lb1_rd, lb0_rd};

  // p0: two older columns per row kept in taps; the third is the incoming column.
  for (genvar r = 0; r < WIN; r++) begin : g_row
    logic signed [DATA_W-1:0] tap_p0 [WIN-1];

    always_ff @(posedge clk) begin
      if (accept) begin
        tap_p0[0] <= tap_p0[1];
        tap_p0[1] <= new_col[r*DATA_W +: DATA_W];
      end
    end

    for (genvar c = 0; c < WIN - 1; c++) begin : g_tap
      assign win_nxt[win_idx(r, c)*DATA_W +: DATA_W] = tap_p0[c];
    end
    assign win_nxt[win_idx(r, WIN-1)*DATA_W +: DATA_W] = new_col[r*DATA_W +: DATA_W];
  end

  // p1: registered window; a fresh window always overwrites the one being taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_vld_p1  <= 1'b0;
      win_data_p1 <= '0;
      win_x_p1    <= '0;
      win_y_p1    <= '0;
    end else begin
      if (accept) begin
        col_q <= col_nxt;
        row_q <= row_nxt;
      end
      if (emit) begin
        win_vld_p1  <= 1'b1;
        win_data_p1 <= win_nxt;
        win_x_p1    <= col_eff - XW'(1);
        win_y_p1    <= row_eff - YW'(1);
      end else if (bus.win_ready) begin
        win_vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.win_valid = win_vld_p1;
  assign bus.win_data  = win_data_p1;
  assign bus.win_x     = win_x_p1;
  assign bus.win_y     = win_y_p1;
endmodule

// File: tb/tb_harris_window_gen.sv
// Directed bench for harris_window_gen on a 4x4 image with sample = y*4+x.
module tb_harris_window_gen;
  import harris_pkg::*;

  localparam int DW = 32;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int XW = $clog2(IW);
  localparam int YW = $clog2(IH);

  logic clk = 1'b0;
  logic reset = 1'b0;

  harris_window_gen_if #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) bus ();

  harris_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic signed [DW-1:0] frame [IW*IH];

  function automatic win_t exp_win(input int cx, input int cy);
    win_t w;
    w = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        w[win_idx(r, c)*DW +: DW] = frame[(cy - 1 + r)*IW + (cx - 1 + c)];
    return w;
  endfunction

  task automatic fill_linear();
    for (int i = 0; i < IW*IH; i++) frame[i] = DW'(i);
  endtask

  // Present one input beat for a single clock; called only while in_ready is high.
  task automatic step(input logic v, input logic signed [DW-1:0] d, input logic sof);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sof   = sof;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    bus.win_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.win_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.win_valid); end
    checks++; if (bus.win_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.win_data); end
    checks++; if (bus.win_x !== '0 || bus.win_y !== '0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", bus.win_x, bus.win_y); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_window();
    fill_linear();
    for (int i = 0; i <= 10; i++) begin
      step(1'b1, frame[i], i == 0);
      if (i == 9) begin
        checks++; if (bus.win_valid !== 1'b0) begin errors++; $display("FAIL first_early: got %b want 0", bus.win_valid); end
      end
    end
    checks++; if (bus.win_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", bus.win_valid); end
    checks++; if (bus.win_x !== XW'(1) || bus.win_y !== YW'(1)) begin errors++; $display("FAIL first_xy: got %0d,%0d want 1,1", bus.win_x, bus.win_y); end
    checks++; if (bus.win_data !== exp_win(1, 1)) begin errors++; $display("FAIL first_data: got %h want %h", bus.win_data, exp_win(1, 1)); end
    step(1'b0, '0, 1'b0);
    checks++; if (bus.win_valid !== 1'b0) begin errors++; $display("FAIL first_drop: got %b want 0", bus.win_valid); end
  endtask

  task automatic test_frame_count();
    int ex [4] = '{1, 2, 1, 2};
    int ey [4] = '{1, 1, 2, 2};
    int k = 0;
    fill_linear();
    for (int i = 0; i < IW*IH; i++) begin
      step(1'b1, frame[i], i == 0);
      if (bus.win_valid === 1'b1) begin
        if (k < 4) begin
          checks++; if (bus.win_x !== XW'(ex[k]) || bus.win_y !== YW'(ey[k])) begin errors++; $display("FAIL frame_xy%0d: got %0d,%0d want %0d,%0d", k, bus.win_x, bus.win_y, ex[k], ey[k]); end
          checks++; if (bus.win_data !== exp_win(ex[k], ey[k])) begin errors++; $display("FAIL frame_data%0d: got %h want %h", k, bus.win_data, exp_win(ex[k], ey[k])); end
        end
        k++;
      end
    end
    checks++; if (k !== 4) begin errors++; $display("FAIL frame_count: got %0d want 4", k); end
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_backpressure();
    int ex [4] = '{1, 2, 1, 2};
    int ey [4] = '{1, 1, 2, 2};
    int idx = 0;
    int k = 0;
    int hold = 0;
    bit seen = 1'b0;
    bit holding;
    win_t snap = '0;
    fill_linear();
    for (int cyc = 0; cyc < 60; cyc++) begin
      bus.win_ready = 1'b1;
      holding = 1'b0;
      if (bus.win_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        snap = bus.win_data;
      end
      if (seen && hold < 3) begin
        bus.win_ready = 1'b0;
        holding = 1'b1;
        hold++;
        checks++; if (bus.win_valid !== 1'b1 || bus.win_x !== XW'(1) || bus.win_y !== YW'(1)) begin errors++; $display("FAIL bp_hold_ctl%0d: got v=%b %0d,%0d want v=1 1,1", hold, bus.win_valid, bus.win_x, bus.win_y); end
        checks++; if (bus.win_data !== snap) begin errors++; $display("FAIL bp_hold_data%0d: got %h want %h", hold, bus.win_data, snap); end
      end
      bus.in_valid = (idx < IW*IH);
      bus.in_data  = DW'(idx);
      bus.in_sof   = (idx == 0);
      #1;
      if (holding) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", hold, bus.in_ready); end
      end
      if (bus.win_valid === 1'b1 && bus.win_ready === 1'b1) begin
        if (k < 4) begin
          checks++; if (bus.win_x !== XW'(ex[k]) || bus.win_y !== YW'(ey[k]) || bus.win_data !== exp_win(ex[k], ey[k])) begin errors++; $display("FAIL bp_win%0d: got %0d,%0d %h want %0d,%0d %h", k, bus.win_x, bus.win_y, bus.win_data, ex[k], ey[k], exp_win(ex[k], ey[k])); end
        end
        k++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) idx++;
      @(negedge clk);
      if (idx >= IW*IH && bus.win_valid !== 1'b1) break;
    end
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.win_ready = 1'b1;
    checks++; if (k !== 4 || idx !== IW*IH || hold !== 3) begin errors++; $display("FAIL bp_totals: got windows=%0d samples=%0d holds=%0d want 4,16,3", k, idx, hold); end
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_negative();
    fill_linear();
    frame[5] = -32'sd5;
    for (int i = 0; i <= 10; i++) step(1'b1, frame[i], i == 0);
    checks++; if (bus.win_data[4*DW +: DW] !== 32'hFFFF_FFFB) begin errors++; $display("FAIL neg_centre: got %h want fffffffb", bus.win_data[4*DW +: DW]); end
    checks++; if (bus.win_data !== exp_win(1, 1)) begin errors++; $display("FAIL neg_window: got %h want %h", bus.win_data, exp_win(1, 1)); end
    frame[5] = 32'sd5;
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_resync();
    int early = 0;
    for (int i = 0; i < 6; i++) step(1'b1, DW'(50 + i), i == 0);
    fill_linear();
    for (int p = 0; p <= 10; p++) begin
      step(1'b1, frame[p], p == 0);
      if (p < 10 && bus.win_valid !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL resync_early: got %0d windows want 0", early); end
    checks++; if (bus.win_valid !== 1'b1 || bus.win_x !== XW'(1) || bus.win_y !== YW'(1)) begin errors++; $display("FAIL resync_xy: got v=%b %0d,%0d want v=1 1,1", bus.win_valid, bus.win_x, bus.win_y); end
    checks++; if (bus.win_data !== exp_win(1, 1)) begin errors++; $display("FAIL resync_data: got %h want %h", bus.win_data, exp_win(1, 1)); end
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int ex [4] = '{1, 2, 1, 2};
    int ey [4] = '{1, 1, 2, 2};
    int k = 0;
    fill_linear();
    for (int i = 0; i <= 10; i++) step(1'b1, frame[i], i == 0);
    reset = 1'b0;
    #1;
    checks++; if (bus.win_valid !== 1'b0 || bus.win_data !== '0 || bus.win_x !== '0 || bus.win_y !== '0) begin errors++; $display("FAIL rstmid_async: got v=%b %0d,%0d %h want v=0 0,0 0", bus.win_valid, bus.win_x, bus.win_y, bus.win_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < IW*IH; i++) begin
      step(1'b1, frame[i], i == 0);
      if (bus.win_valid === 1'b1) begin
        if (k < 4) begin
          checks++; if (bus.win_x !== XW'(ex[k]) || bus.win_y !== YW'(ey[k]) || bus.win_data !== exp_win(ex[k], ey[k])) begin errors++; $display("FAIL rstmid_win%0d: got %0d,%0d %h want %0d,%0d %h", k, bus.win_x, bus.win_y, bus.win_data, ex[k], ey[k], exp_win(ex[k], ey[k])); end
        end
        k++;
      end
    end
    checks++; if (k !== 4) begin errors++; $display("FAIL rstmid_count: got %0d want 4", k); end
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_frame_count();
    test_backpressure();
    test_negative();
    test_resync();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
